// File: rtl/lib_pow2_serializer.sv
// Serializes the set bits of a vector into one-hot beats (index, beat count, last flag),
// lowest-first or highest-first, with valid/ready on both sides.
module lib_pow2_serializer #(
  parameter int WIDTH   = 4,
  parameter int LSB_MSB = 0,
  parameter int IDX_W   = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_vect,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_onehot,
  output logic [IDX_W-1:0] m_idx,
  output logic [CNT_W-1:0] m_cnt,
  output logic             m_last,
  output logic             m_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             zero_f;
  logic             beat;
  logic             accept;

  // First set bit in scan order; the later loop hit overwrites, so the loop runs
  // from the far end toward the preferred end.
  function automatic logic [WIDTH-1:0] ffs(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    if (LSB_MSB == 0) begin
      for (int i = WIDTH-1; i >= 0; i--) begin
        if (v[i]) begin
          r    = '0;
          r[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          r    = '0;
          r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    m_valid  = (state == BUSY);
    m_onehot = ffs(res);
    m_idx    = encode(m_onehot);
    m_last   = ((res & ~m_onehot) == '0);
    m_cnt    = cnt;
    m_zero   = zero_f;
    beat     = m_valid & m_ready;
    // Last-beat term lets the next vector load in the same cycle the old one retires.
    s_ready  = (state == IDLE) | (beat & m_last);
    accept   = s_valid & s_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res    <= '0;
      cnt    <= '0;
      zero_f <= 1'b0;
    end else if (accept) begin
      state  <= BUSY;
      res    <= s_vect;
      cnt    <= '0;
      zero_f <= (s_vect == '0);
    end else if (beat) begin
      // Clearing the retired bit on the last beat too leaves res empty while idle.
      res <= res & ~m_onehot;
      if (m_last) begin
        state <= IDLE;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lib_pow2_serializer.sv
// Randomized and directed bench for lib_pow2_serializer; one instance per scan order,
// both fed the same stream and checked against a queue-based beat model.
module tb_lib_pow2_serializer;
  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s_valid, m_ready;
  logic [W-1:0]  s_vect;
  logic          s_ready_a, m_valid_a, m_last_a, m_zero_a;
  logic          s_ready_b, m_valid_b, m_last_b, m_zero_b;
  logic [W-1:0]  m_onehot_a, m_onehot_b;
  logic [IW-1:0] m_idx_a, m_idx_b;
  logic [CW-1:0] m_cnt_a, m_cnt_b;

  lib_pow2_serializer #(.WIDTH(W), .LSB_MSB(0)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_vect(s_vect),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_onehot(m_onehot_a), .m_idx(m_idx_a),
    .m_cnt(m_cnt_a), .m_last(m_last_a), .m_zero(m_zero_a));

  lib_pow2_serializer #(.WIDTH(W), .LSB_MSB(1)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_vect(s_vect),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_onehot(m_onehot_b), .m_idx(m_idx_b),
    .m_cnt(m_cnt_b), .m_last(m_last_b), .m_zero(m_zero_b));

  typedef struct packed {
    logic [W-1:0]  oh;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          last;
    logic          zero;
    logic [W-1:0]  vec;
  } beat_t;

  beat_t        qa[$], qb[$];
  logic [W-1:0] vin[$];
  logic [W-1:0] xa, xb;
  int           checks = 0, errors = 0;
  int           mr_mode = 0, fd_mode = 0, tcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beats of one vector, in ascending (a) and descending (b) bit order.
  task automatic push_vec(input logic [W-1:0] v);
    beat_t b;
    int k, n;
    k = $countones(v);
    if (k == 0) begin
      b = '{oh: '0, idx: '0, cnt: '0, last: 1'b1, zero: 1'b1, vec: v};
      qa.push_back(b);
      qb.push_back(b);
      return;
    end
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        b = '{oh: '0, idx: IW'(i), cnt: CW'(n), last: (n == k-1), zero: 1'b0, vec: v};
        b.oh[i] = 1'b1;
        qa.push_back(b);
        n++;
      end
    end
    n = 0;
    for (int i = W-1; i >= 0; i--) begin
      if (v[i]) begin
        b = '{oh: '0, idx: IW'(i), cnt: CW'(n), last: (n == k-1), zero: 1'b0, vec: v};
        b.oh[i] = 1'b1;
        qb.push_back(b);
        n++;
      end
    end
  endtask

  task automatic side_check(input string s, input int n, input beat_t e, input logic sr,
                            input logic mv, input logic [W-1:0] oh, input logic [IW-1:0] idx,
                            input logic [CW-1:0] cnt, input logic last, input logic zero);
    check_eq({s, ".s_ready"}, sr, (n == 0) || (m_ready && n == 1));
    check_eq({s, ".m_valid"}, mv, n != 0);
    if (n != 0) begin
      check_eq({s, ".m_onehot"}, oh, e.oh);
      check_eq({s, ".m_idx"}, idx, e.idx);
      check_eq({s, ".m_cnt"}, cnt, e.cnt);
      check_eq({s, ".m_last"}, last, e.last);
      check_eq({s, ".m_zero"}, zero, e.zero);
    end
  endtask

  task automatic drive();
    tcnt++;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = (tcnt % 3 == 0);
    endcase
    s_valid = (vin.size() != 0) && (fd_mode == 0 || $urandom_range(0, 3) != 0);
    s_vect  = s_valid ? vin[0] : W'($urandom);
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    side_check("a", qa.size(), (qa.size() != 0) ? qa[0] : '0, s_ready_a, m_valid_a,
               m_onehot_a, m_idx_a, m_cnt_a, m_last_a, m_zero_a);
    side_check("b", qb.size(), (qb.size() != 0) ? qb[0] : '0, s_ready_b, m_valid_b,
               m_onehot_b, m_idx_b, m_cnt_b, m_last_b, m_zero_b);
    acc = s_valid && ((qa.size() == 0) || (m_ready && qa.size() == 1));
    if (rst) begin
      qa.delete();
      qb.delete();
      xa = '0;
      xb = '0;
    end else begin
      if (m_ready && qa.size() != 0) begin
        xa ^= m_onehot_a;
        if (qa[0].last) begin
          check_eq("xor_a", xa, qa[0].vec);
          xa = '0;
        end
        void'(qa.pop_front());
      end
      if (m_ready && qb.size() != 0) begin
        xb ^= m_onehot_b;
        if (qb[0].last) begin
          check_eq("xor_b", xb, qb[0].vec);
          xb = '0;
        end
        void'(qb.pop_front());
      end
      if (acc) push_vec(vin.pop_front());
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((vin.size() != 0 || qa.size() != 0 || qb.size() != 0) && c < budget) begin
      step();
      c++;
    end
    check_eq("drain", vin.size() + qa.size() + qb.size(), 0);
  endtask

  initial begin
    int c;
    xa = '0;
    xb = '0;
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_vect = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst.s_ready", s_ready_a, 1);
    check_eq("rst.m_valid", m_valid_a, 0);
    check_eq("rst.m_onehot", m_onehot_a, 0);
    check_eq("rst.m_idx", m_idx_a, 0);
    check_eq("rst.m_cnt", m_cnt_a, 0);
    check_eq("rst.m_last", m_last_a, 1);
    check_eq("rst.m_zero", m_zero_a, 0);
    check_eq("rst.m_valid_b", m_valid_b, 0);
    check_eq("rst.s_ready_b", s_ready_b, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();

    // Directed vectors, then back-to-back and a zero vector at full rate.
    vin.push_back(8'hA4);
    drain(50);
    vin.push_back(8'h00);
    vin.push_back(8'h81);
    vin.push_back(8'h01);
    vin.push_back(8'h00);
    vin.push_back(8'h10);
    drive();
    drain(50);

    // Stall pattern on a full vector.
    mr_mode = 2;
    vin.push_back(8'hFF);
    drive();
    drain(100);

    // Reset in the middle of a vector.
    mr_mode = 0;
    vin.push_back(8'hF0);
    drive();
    c = 0;
    while (qa.size() != 2 && c < 20) begin
      step();
      c++;
    end
    check_eq("mid_rst.reach", qa.size(), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    vin.push_back(8'h01);
    drive();
    drain(50);

    // Random traffic with random backpressure and source gaps.
    mr_mode = 1;
    fd_mode = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       vin.push_back('0);
        1:       vin.push_back(W'($urandom) & W'($urandom));
        default: vin.push_back(W'($urandom));
      endcase
    end
    drive();
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lib_pow2_serializer.md
# lib_pow2_serializer

Sequential stage that consumes a packed bit vector and emits its set bits one per cycle as one-hot beats, each with the bit index, beat count and last flag. It sits in the error-location path downstream of the locator bitmap and replaces the fully parallel `lib_decmps_to_pow2` fan-out where area matters more than latency. The selection order is the same as `lib_ffs`: lowest bit first when LSB_MSB=0, highest bit first when LSB_MSB=1. Input and output use valid/ready handshakes.

## Interface
- WIDTH, 4, input vector width; must be ≥2
- LSB_MSB, 0, scan order; 0 = bit 0 first, 1 = bit WIDTH-1 first
- IDX_W, $clog2(WIDTH), index width (derived; do not override)
- CNT_W, $clog2(WIDTH+1), beat-count width (derived)
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  input vector valid
- s_ready  output  1  block can accept a vector this cycle
- s_vect  input  WIDTH  vector to decompose
- m_valid  output  1  output beat valid
- m_ready  input  1  downstream accepts the beat
- m_onehot  output  WIDTH  current one-hot bit; all zeros on an empty beat
- m_idx  output  IDX_W  binary index of the m_onehot bit; 0 on an empty beat
- m_cnt  output  CNT_W  beat number within the vector, starting at 0
- m_last  output  1  final beat of the current vector
- m_zero  output  1  input vector was all zeros (single empty beat)

## Operation
- State machine has two states:
  - IDLE: m_valid=0.
  - BUSY: m_valid=1.
- Registers:
  - res: residual vector, WIDTH bits
  - cnt: beat counter, CNT_W bits
  - zero_f: empty-vector flag
- Output logic is combinational from the registers, using one `lib_ffs` instance on res with base=1:
  - m_onehot = ffs(res)
  - m_idx = encode(m_onehot)
  - m_last = ((res & ~m_onehot) == 0)
  - m_zero = zero_f
  - m_cnt = cnt
- Accept: s_ready = (state==IDLE) | (m_valid & m_ready & m_last).
  - On s_valid & s_ready: res ← s_vect, cnt ← 0, zero_f ← (s_vect==0), state ← BUSY.
- Output handshake, on m_valid & m_ready:
  - If not last: res ← res & ~m_onehot and cnt ← cnt+1.
  - If last with no new accept in the same cycle: state ← IDLE.
  - If last with a simultaneous accept: the accept wins, the new vector loads and state stays BUSY. This gives back-to-back vectors with no bubble.
- Zero vector:
  - Exactly one beat: m_onehot=0, m_idx=0, m_cnt=0, m_last=1, m_zero=1.
- Backpressure:
  - While m_valid & ~m_ready, every m_* output holds stable and res/cnt do not change.
  - s_vect is ignored while s_ready=0.
- A vector with k set bits (k≥1) produces exactly k beats.
  - m_cnt runs 0..k-1.
  - The XOR of all m_onehot beats equals the input vector.
- cnt never exceeds WIDTH-1 because there are at most WIDTH beats, so no wrap is possible.

## Timing
- Reset values: state=IDLE, res=0, cnt=0, zero_f=0. The outputs follow from these:
  - s_ready=1
  - m_valid=0
  - m_onehot=0
  - m_idx=0
  - m_cnt=0
  - m_last=1
  - m_zero=0
- Reset asserted mid-vector: the next edge returns the block to IDLE. The remaining beats are dropped; no partial flush.
- rst has priority over both handshakes in the same cycle.
- Latency: a vector accepted at edge N gives its first beat m_valid=1 in cycle N+1.
- Throughput: with m_ready=1, one beat per cycle, so a vector with k set bits takes max(k,1) cycles.
- Combinational paths:
  - m_ready → s_ready, through the last-beat term.
  - No combinational path from s_valid to m_*.

## Test plan
- WIDTH=8, LSB_MSB=0, s_vect=8'b1010_0100, m_ready=1 → three beats: onehot 0x04/idx 2/cnt 0, 0x20/idx 5/cnt 1, 0x80/idx 7/cnt 2 with m_last=1; s_ready=1 in the last-beat cycle.
- Same vector with LSB_MSB=1 → beats idx 7, 5, 2 in that order; XOR of the beats equals 0xA4.
- s_vect=0x00 → one beat: onehot=0, m_zero=1, m_last=1, m_cnt=0; next vector is accepted in the same cycle.
- Back-to-back 0x81 then 0x01 with s_valid held high → beats idx 0, 7(last), 0(last) in consecutive cycles with no bubble.
- s_vect=0xFF with m_ready toggling 1,0,0,1,… → outputs hold during stalls; eight beats in total, m_cnt 0..7, m_last only on idx 7.
- Load 0xF0 and assert rst after the second beat → next cycle m_valid=0, s_ready=1; a fresh 0x01 yields a single beat, idx 0, cnt 0.
